// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer (main + skid) and optional branch resolution.
// Define EX_MEM_BRANCH_RESOLVE_EN to compile the registered branch_taken/branch_target logic.
module ex_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic        zero_flag,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        branch,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] branch_offset,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_dest_reg,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_reg_write,
  output logic        branch_taken,
  output logic [31:0] branch_target
);

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  dest;
    logic        mr;
    logic        mw;
    logic        rw;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, in_e;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic   accept, xfer;

  assign in_e   = '{alu: alu_result, sdata: store_data, dest: dest_reg,
                    mr: mem_read, mw: mem_write, rw: reg_write};
  assign in_ready = !skid_vld_q;
  assign accept   = in_valid && in_ready;
  assign xfer     = main_vld_q && out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // in_ready is low here, so only a skid->main move can happen
      if (xfer) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_q || xfer) begin
        main_d     = in_e;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_e;
        skid_vld_d = 1'b1;
      end
    end else if (xfer) begin
      main_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid      = main_vld_q;
  assign out_alu_result = main_q.alu;
  assign out_store_data = main_q.sdata;
  assign out_dest_reg   = main_q.dest;
  assign out_mem_read   = main_q.mr;
  assign out_mem_write  = main_q.mw;
  assign out_reg_write  = main_q.rw;

`ifdef EX_MEM_BRANCH_RESOLVE_EN
  logic        br_taken_q, br_taken_d;
  logic [31:0] br_target_q, br_target_d;

  always_comb begin
    br_taken_d  = accept && branch && zero_flag && !flush;
    br_target_d = br_taken_d ? pc_plus4 + {branch_offset[29:0], 2'b00} : br_target_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign branch_taken  = br_taken_q;
  assign branch_target = br_target_q;
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{branch, zero_flag, pc_plus4, branch_offset};
  assign branch_taken  = 1'b0;
  assign branch_target = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: an in-order queue model (capacity 2) predicts
// acceptance, output order and branch results; a negedge monitor compares.
module tb_ex_mem_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, zero_flag, mem_read, mem_write, reg_write, branch;
  logic        flush, out_valid, out_ready, out_mem_read, out_mem_write, out_reg_write, branch_taken;
  logic [31:0] alu_result, store_data, pc_plus4, branch_offset;
  logic [31:0] out_alu_result, out_store_data, branch_target;
  logic [4:0]  dest_reg, out_dest_reg;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .zero_flag(zero_flag), .store_data(store_data),
    .dest_reg(dest_reg), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .branch(branch), .pc_plus4(pc_plus4),
    .branch_offset(branch_offset), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu_result(out_alu_result),
    .out_store_data(out_store_data), .out_dest_reg(out_dest_reg),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .branch_taken(branch_taken),
    .branch_target(branch_target)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  dest;
    logic        mr, mw, rw;
  } item_t;

  item_t       sb[$];
  logic        exp_taken;
  logic [31:0] exp_target;
  bit          live = 1'b0;
  int          tests = 0, fails = 0;

`ifdef EX_MEM_BRANCH_RESOLVE_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two instructions; branch target from plain arithmetic.
  always @(posedge clk) begin : model
    bit acc, xfer;
    item_t it;
    xfer = (sb.size() > 0) && out_ready;
    acc  = in_valid && (sb.size() < 2);
    if (reset) begin
      sb.delete();
      exp_taken  = 1'b0;
      exp_target = '0;
      live       = 1'b1;
    end else if (flush) begin
      sb.delete();
      exp_taken = 1'b0;
    end else begin
      if (xfer) void'(sb.pop_front());
      if (acc) begin
        it = '{alu: alu_result, sdata: store_data, dest: dest_reg,
               mr: mem_read, mw: mem_write, rw: reg_write};
        sb.push_back(it);
      end
      exp_taken = BR_EN && acc && branch && zero_flag;
      if (exp_taken) exp_target = pc_plus4 + branch_offset * 32'd4;
    end
  end

  always @(negedge clk) begin : monitor
    if (live) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
      if (out_valid && sb.size() > 0) begin
        chk("out_alu_result", out_alu_result, sb[0].alu);
        chk("out_store_data", out_store_data, sb[0].sdata);
        chk("out_ctrl", {24'd0, out_dest_reg, out_mem_read, out_mem_write, out_reg_write},
            {24'd0, sb[0].dest, sb[0].mr, sb[0].mw, sb[0].rw});
      end
      chk("branch_taken", {31'd0, branch_taken}, {31'd0, exp_taken});
      chk("branch_target", branch_target, exp_target);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] a);
    in_valid   = v;
    alu_result = a;
    store_data = ~a;
    dest_reg   = a[4:0];
    mem_read   = a[0];
    mem_write  = a[1];
    reg_write  = a[2];
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; branch = 1'b0; zero_flag = 1'b0;
    pc_plus4 = '0; branch_offset = '0;
    set_in(1'b0, 32'd0);
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset alu", out_alu_result, 32'd0);
    chk("reset target", branch_target, 32'd0);

    // single instruction, one-cycle latency
    set_in(1'b1, 32'h5); out_ready = 1'b1;
    step(); set_in(1'b0, 32'h0);
    @(negedge clk);
    chk("lat1 valid", {31'd0, out_valid}, 32'd1);
    chk("lat1 alu", out_alu_result, 32'h5);

    // backpressure: A main, B skid, C held off
    step();
    out_ready = 1'b0;
    set_in(1'b1, 32'hA0); step();
    set_in(1'b1, 32'hB1); step();
    set_in(1'b1, 32'hC2); step();
    @(negedge clk);
    chk("skid in_ready", {31'd0, in_ready}, 32'd0);
    chk("skid head A", out_alu_result, 32'hA0);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("drain B", out_alu_result, 32'hB1);
    step(); set_in(1'b0, 32'h0);
    @(negedge clk);
    chk("drain C valid", {31'd0, out_valid}, 32'd1);
    chk("drain C", out_alu_result, 32'hC2);
    step();
    @(negedge clk);
    chk("drain empty", {31'd0, out_valid}, 32'd0);

    // branch resolution with negative offset
    set_in(1'b1, 32'h7); branch = 1'b1; zero_flag = 1'b1;
    pc_plus4 = 32'h0000_1000; branch_offset = 32'hFFFF_FFFF;
    step(); set_in(1'b0, 32'h0); branch = 1'b0; zero_flag = 1'b0;
    @(negedge clk);
    chk("br taken", {31'd0, branch_taken}, {31'd0, BR_EN});
    chk("br target", branch_target, BR_EN ? 32'h0000_0FFC : 32'h0);
    step();
    @(negedge clk);
    chk("br one-shot", {31'd0, branch_taken}, 32'd0);
    chk("br hold", branch_target, BR_EN ? 32'h0000_0FFC : 32'h0);

    // flush with both entries full drops the concurrent input
    out_ready = 1'b0;
    set_in(1'b1, 32'h11); step();
    set_in(1'b1, 32'h22); step();
    set_in(1'b1, 32'hDEAD); flush = 1'b1;
    step(); flush = 1'b0; set_in(1'b0, 32'h0);
    @(negedge clk);
    chk("flush valid", {31'd0, out_valid}, 32'd0);
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1; step(); step();

    // reset under backpressure, with a pending branch pulse
    out_ready = 1'b0;
    set_in(1'b1, 32'h33); branch = 1'b1; zero_flag = 1'b1;
    step(); set_in(1'b0, 32'h0); branch = 1'b0; zero_flag = 1'b0; reset = 1'b1;
    step(); reset = 1'b0;
    @(negedge clk);
    chk("rst mid valid", {31'd0, out_valid}, 32'd0);
    chk("rst mid alu", out_alu_result, 32'd0);
    chk("rst mid taken", {31'd0, branch_taken}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom);
      out_ready     = $urandom_range(0, 9) < 7;
      flush         = $urandom_range(0, 39) == 0;
      reset         = $urandom_range(0, 299) == 0;
      branch        = $urandom_range(0, 2) == 0;
      zero_flag     = $urandom_range(0, 1) == 1;
      pc_plus4      = $urandom;
      branch_offset = $urandom;
      step();
    end
    set_in(1'b0, 32'h0); flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  input  1  execute stage presents an instruction.
REQ-004 SHALL have ports: in_ready  output  1  stage can accept an instruction this cycle.
REQ-005 SHALL have ports: alu_result  input  32  ALU result; zero_flag  input  1  ALU zero flag.
REQ-006 SHALL have ports: store_data  input  32  rt value for stores; dest_reg  input  5  writeback register index.
REQ-007 SHALL have ports: mem_read, mem_write, reg_write, branch  input  1 each  decoded control bits.
REQ-008 SHALL have ports: pc_plus4  input  32; branch_offset  input  32  sign-extended immediate.
REQ-009 SHALL have ports: flush  input  1  discard all held and incoming instructions.
REQ-010 SHALL have ports: out_valid  output  1; out_ready  input  1  memory-stage handshake.
REQ-011 SHALL have ports: out_alu_result, out_store_data  output  32; out_dest_reg  output  5; out_mem_read, out_mem_write, out_reg_write  output  1.
REQ-012 SHALL have ports: branch_taken  output  1; branch_target  output  32.

Function
REQ-013 SHALL hold two entries: main (drives outputs) and skid; each entry has a valid bit plus all payload fields.
REQ-014 SHALL accept input when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-015 SHALL drive in_ready = !skid_valid, registered (no combinational path from out_ready to in_ready).
REQ-016 SHALL drive out_valid = main_valid and all out_* payload directly from the main entry registers.
REQ-017 SHALL, on accept with main empty or main transferring and skid empty, load input into main; latency in -> out exactly 1 cycle.
REQ-018 SHALL, on accept while main valid and not transferring, load input into skid.
REQ-019 SHALL, on transfer with skid valid, move skid into main and clear skid the same edge; no accept occurs that cycle (in_ready low).
REQ-020 SHALL keep main payload stable while out_valid && !out_ready.
REQ-021 SHALL, on flush, clear main_valid and skid_valid at the edge and drop any concurrent input; flush overrides accept and transfer.
REQ-022 SHALL never lose, duplicate or reorder instructions; throughput 1 per cycle when out_ready stays high.
REQ-023 SHALL compute branch_target = pc_plus4 + (branch_offset << 2), modulo 2^32, wrap ignored.
REQ-024 SHALL assert branch_taken for exactly one cycle, the cycle after an accept with branch && zero_flag, registered with branch_target; suppressed if flush is high in the accept cycle.
REQ-025 SHALL hold branch_target at its last value when branch_taken is low.

Reset
REQ-026 SHALL on reset clear main_valid, skid_valid, branch_taken; out_valid=0, in_ready=1 the cycle after reset.
REQ-027 SHALL on reset zero all payload outputs and branch_target.
REQ-028 SHALL, with reset asserted mid-operation, discard all entries; reset dominates flush and handshakes.

Configuration
REQ-029 SHALL compile branch resolution only when macro EX_MEM_BRANCH_RESOLVE_EN is defined.
REQ-030 SHALL, with EX_MEM_BRANCH_RESOLVE_EN defined, behave per REQ-023..REQ-025.
REQ-031 SHALL, without EX_MEM_BRANCH_RESOLVE_EN, tie branch_taken=0 and branch_target=0, ignore branch, pc_plus4, branch_offset, zero_flag; pipeline behaviour unchanged.

Verification
REQ-032 SHALL cover: reset, in_valid=1, alu_result=0x0000_0005, out_ready=1 -> next cycle out_valid=1, out_alu_result=5; in_ready=1 throughout.
REQ-033 SHALL cover: out_ready=0, three back-to-back inputs A,B,C -> A in main, B in skid, in_ready=0 and C held; out_ready=1 -> outputs A,B,C in order, no gaps after A.
REQ-034 SHALL cover: branch=1, zero_flag=1, pc_plus4=0x0000_1000, branch_offset=0xFFFF_FFFF -> next cycle branch_taken=1 one cycle, branch_target=0x0000_0FFC.
REQ-035 SHALL cover: main and skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
REQ-036 SHALL cover: reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_alu_result=0, branch_taken=0.
REQ-037 SHALL cover: build without EX_MEM_BRANCH_RESOLVE_EN, repeat REQ-034 stimulus -> branch_taken=0, branch_target=0, data path still passes.
